seq_generator: RTL and testbench
================================

SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits (2..16).
REQ-002 Parameter DIV, default 8: system clocks per serial bit (1..65535).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; one clock, no other clock domain.
REQ-005 start  input  1  request to transmit a frame; accepted only when ready=1.
REQ-006 pattern  input  PAT_W  bit pattern to send, MSB first; sampled on accept only.
REQ-007 repeat_cnt  input  4  number of back-to-back pattern repetitions; sampled on accept only.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high while a frame is being sent (inverse of ready).
REQ-010 seq_out  output  1  serial bit stream consumed by the team's sequence detector.
REQ-011 bit_strobe  output  1  one-cycle pulse in the first cycle each new bit appears on seq_out.
REQ-012 done  output  1  one-cycle pulse after the final bit period of a frame.

Function
REQ-013 States: IDLE, SHIFT, DONE; all outputs registered.
REQ-014 Accept = start & ready in cycle t; pattern and repeat_cnt are latched at the edge ending t; state->SHIFT.
REQ-015 repeat_cnt=0 is treated as 1; total bits N = PAT_W * max(repeat_cnt,1).
REQ-016 Bit k (k=0..N-1) is pattern[PAT_W-1-(k mod PAT_W)], driven on seq_out from cycle t+1+k*DIV and held exactly DIV cycles.
REQ-017 bit_strobe is high in cycles t+1+k*DIV for every k, and low otherwise.
REQ-018 Bit-period divider counts 0..DIV-1, is cleared on accept, and wraps to 0 at each bit boundary; with DIV=1 a new bit appears every cycle.
REQ-019 Shift register reloads from the latched pattern at each repetition boundary, with no gap cycles between repetitions.
REQ-020 After bit N-1 finishes its DIV cycles, state=DONE for exactly one cycle (cycle t+1+N*DIV): done=1, seq_out=0, busy=1.
REQ-021 DONE->IDLE unconditionally; start asserted during DONE is ignored; first possible re-accept is cycle t+2+N*DIV.
REQ-022 start while busy has no effect on the current frame and is not queued.
REQ-023 Changes to pattern or repeat_cnt after accept have no effect on the current frame.
REQ-024 In IDLE: seq_out=0, bit_strobe=0, done=0, ready=1, busy=0.

Reset
REQ-025 reset=1 at a clock edge forces state IDLE, clears divider, shift register and repetition counter, and sets seq_out=0, bit_strobe=0, done=0, ready=1, busy=0 from the next cycle.
REQ-026 Reset takes priority over start in the same cycle; no accept occurs.
REQ-027 Reset mid-frame aborts silently: no done pulse, no further bits.

Structure
REQ-028 Shared package seq_pkg holds the state encoding (IDLE/SHIFT/DONE) and default PAT_W/DIV constants shared with the detector.
REQ-029 The bit-period divider is a sub-module bit_tick_gen (inputs clk, reset, clear; output tick), reusable by the detector.

Verification
REQ-030 PAT_W=4, DIV=4, pattern=1011, repeat_cnt=1, accept at t -> seq_out 1,0,1,1 each held 4 cycles from t+1; bit_strobe at t+1,t+5,t+9,t+13; done at t+17; ready at t+18.
REQ-031 repeat_cnt=3, pattern=1011, DIV=2 -> 12 bits 1011 1011 1011 with no gaps; done at t+25.
REQ-032 DIV=1, pattern=0110, repeat_cnt=0 -> bits 0,1,1,0 on consecutive cycles t+1..t+4; done at t+5.
REQ-033 start pulsed at t+6 during a frame with a different pattern -> original frame unchanged, no second frame follows.
REQ-034 reset asserted at t+7 of REQ-030 frame -> seq_out=0, busy=0 from t+8; no done pulse; a new accept at t+9 starts cleanly.
REQ-035 Loopback: seq_out driven into the sequence detector with a matching DIV -> the detected output pulses once per occurrence of the target pattern.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator and its companion detector:
// FSM state encoding, default frame geometry and repetition helper.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_DIV   = 8;

    // A repeat count of zero still sends the pattern once.
    function automatic logic [3:0] eff_reps(input logic [3:0] repeat_cnt);
        return (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each
// serial bit period. Shared with the sequence detector.
module bit_tick_gen #(
    parameter int DIV = seq_pkg::DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_generator.sv
// Serial pattern generator: on accept, shifts out a latched pattern MSB first,
// repeated back to back, one bit per DIV clocks, then pulses done.
module seq_generator
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       repeat_cnt,
    output logic             ready,
    output logic             busy,
    output logic             seq_out,
    output logic             bit_strobe,
    output logic             done
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    seq_state_t       state;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] shift_q;
    logic [IDX_W-1:0] bit_idx;
    logic [3:0]       reps_left;
    logic             accept;
    logic             tick;
    logic             last_bit;

    assign accept   = start & ready;
    assign last_bit = (bit_idx == IDX_W'(PAT_W - 1));

    // Divider restarts on accept so the first bit gets a full DIV cycles.
    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pat_q      <= '0;
            shift_q    <= '0;
            bit_idx    <= '0;
            reps_left  <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            seq_out    <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    seq_out    <= 1'b0;
                    bit_strobe <= 1'b0;
                    done       <= 1'b0;
                    if (accept) begin
                        state      <= ST_SHIFT;
                        pat_q      <= pattern;
                        shift_q    <= pattern;
                        bit_idx    <= '0;
                        reps_left  <= eff_reps(repeat_cnt);
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        seq_out    <= pattern[PAT_W-1];
                        bit_strobe <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    bit_strobe <= 1'b0;
                    if (tick) begin
                        if (!last_bit) begin
                            shift_q    <= shift_q << 1;
                            seq_out    <= shift_q[PAT_W-2];
                            bit_idx    <= bit_idx + 1'b1;
                            bit_strobe <= 1'b1;
                        end else if (reps_left > 4'd1) begin
                            // Next repetition starts immediately, no gap bit.
                            reps_left  <= reps_left - 4'd1;
                            shift_q    <= pat_q;
                            seq_out    <= pat_q[PAT_W-1];
                            bit_idx    <= '0;
                            bit_strobe <= 1'b1;
                        end else begin
                            state   <= ST_DONE;
                            seq_out <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: three instances (DIV=4,2,1) checked every cycle
// against a time-based frame model, plus literal expectations at key cycles.
module tb_seq_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start = '0;
    logic [3:0] pattern = '0;
    logic [3:0] repeat_cnt = '0;
    logic [2:0] ready, busy, seq_out, bit_strobe, done;

    int  cyc = 0;
    int  n_total = 0;
    int  n_pass = 0;
    bit  chk_en = 1'b0;

    // Frame model: accept cycle, latched pattern and bit count per instance.
    bit         m_active [3];
    int         m_acc    [3];
    int         m_n      [3];
    logic [3:0] m_pat    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        seq_generator #(.PAT_W(4), .DIV(D)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[g]),
            .pattern    (pattern),
            .repeat_cnt (repeat_cnt),
            .ready      (ready[g]),
            .busy       (busy[g]),
            .seq_out    (seq_out[g]),
            .bit_strobe (bit_strobe[g]),
            .done       (done[g])
        );
    end

    function automatic int div_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    endfunction

    // Expected {ready, busy, seq_out, bit_strobe, done} in cycle c.
    function automatic logic [4:0] expect_out(input int g, input int c);
        int rel, span, k;
        logic [3:0] p;
        if (!m_active[g]) return 5'b10000;
        rel  = c - m_acc[g] - 1;
        span = m_n[g] * div_of(g);
        if (rel < 0 || rel > span) return 5'b10000;
        if (rel == span) return 5'b01001;
        k = rel / div_of(g);
        p = m_pat[g];
        return {1'b0, 1'b1, p[3 - (k % 4)], ((rel % div_of(g)) == 0), 1'b0};
    endfunction

    function automatic bit model_ready(input int g, input int c);
        logic [4:0] e;
        e = expect_out(g, c);
        return e[4];
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (reset) begin
                m_active[g] <= 1'b0;
            end else if (start[g] && model_ready(g, cyc)) begin
                m_active[g] <= 1'b1;
                m_acc[g]    <= cyc;
                m_pat[g]    <= pattern;
                m_n[g]      <= 4 * ((repeat_cnt == 4'd0) ? 1 : int'(repeat_cnt));
            end
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 3; g++)
                check($sformatf("model_g%0d", g),
                      {3'b000, ready[g], busy[g], seq_out[g], bit_strobe[g], done[g]},
                      {3'b000, expect_out(g, cyc)});
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int t;

        // Reset with start held high: reset wins, nothing is accepted.
        start = 3'b001;
        pattern = 4'b1111;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_idle", {3'b0, ready[0], busy[0], seq_out[0], bit_strobe[0], done[0]}, 8'b0001_0000);
        reset = 1'b0;
        start = '0;
        @(negedge clk);
        check("post_reset_ready", {5'b0, ready}, 8'b0000_0111);

        // DIV=4, 1011 x1; later pattern changes and a busy start are ignored.
        pattern = 4'b1011; repeat_cnt = 4'd1; start = 3'b001; t = cyc;
        @(negedge clk);
        start = '0; pattern = 4'b0000; repeat_cnt = 4'd5;
        check("f30_t1", {6'b0, seq_out[0], bit_strobe[0]}, 8'd3);
        at_cycle(t + 2);  check("f30_t2", {6'b0, seq_out[0], bit_strobe[0]}, 8'd2);
        at_cycle(t + 5);  check("f30_t5", {6'b0, seq_out[0], bit_strobe[0]}, 8'd1);
        at_cycle(t + 6);  start = 3'b001; pattern = 4'b0100;
        at_cycle(t + 7);  start = '0;
        at_cycle(t + 9);  check("f30_t9", {6'b0, seq_out[0], bit_strobe[0]}, 8'd3);
        at_cycle(t + 13); check("f30_t13", {6'b0, seq_out[0], bit_strobe[0]}, 8'd3);
        at_cycle(t + 16); check("f30_t16", {6'b0, seq_out[0], done[0]}, 8'd2);
        at_cycle(t + 17); check("f30_done", {5'b0, done[0], seq_out[0], busy[0]}, 8'd5);
        at_cycle(t + 18); check("f30_ready", {5'b0, ready[0], busy[0], done[0]}, 8'd4);
        at_cycle(t + 22); check("f33_no_second", {6'b0, busy[0], seq_out[0]}, 8'd0);

        // DIV=2, 1011 x3: twelve bits with no gaps.
        pattern = 4'b1011; repeat_cnt = 4'd3; start = 3'b010; t = cyc;
        @(negedge clk);
        start = '0;
        check("f31_t1", {6'b0, seq_out[1], bit_strobe[1]}, 8'd3);
        at_cycle(t + 9);  check("f31_rep2", {6'b0, seq_out[1], bit_strobe[1]}, 8'd3);
        at_cycle(t + 11); check("f31_t11", {6'b0, seq_out[1], bit_strobe[1]}, 8'd1);
        at_cycle(t + 23); check("f31_last", {6'b0, seq_out[1], bit_strobe[1]}, 8'd3);
        at_cycle(t + 25); check("f31_done", {7'b0, done[1]}, 8'd1);
        at_cycle(t + 28);

        // DIV=1, 0110 with repeat_cnt=0 treated as one repetition.
        pattern = 4'b0110; repeat_cnt = 4'd0; start = 3'b100; t = cyc;
        @(negedge clk);
        start = '0;
        check("f32_b0", {6'b0, seq_out[2], bit_strobe[2]}, 8'd1);
        at_cycle(t + 2); check("f32_b1", {6'b0, seq_out[2], bit_strobe[2]}, 8'd3);
        at_cycle(t + 3); check("f32_b2", {7'b0, seq_out[2]}, 8'd1);
        at_cycle(t + 4); check("f32_b3", {7'b0, seq_out[2]}, 8'd0);
        at_cycle(t + 5); check("f32_done", {6'b0, done[2], busy[2]}, 8'd3);
        at_cycle(t + 8);

        // DIV=4 frame aborted by reset, then a clean restart.
        pattern = 4'b1011; repeat_cnt = 4'd1; start = 3'b001; t = cyc;
        @(negedge clk);
        start = '0;
        at_cycle(t + 7);  reset = 1'b1;
        at_cycle(t + 8);  reset = 1'b0;
        check("f34_abort", {5'b0, seq_out[0], busy[0], ready[0]}, 8'd1);
        at_cycle(t + 9);  pattern = 4'b1100; start = 3'b001;
        at_cycle(t + 10); start = '0;
        check("f34_restart", {5'b0, seq_out[0], bit_strobe[0], busy[0]}, 8'd7);
        at_cycle(t + 14); check("f34_k1", {6'b0, seq_out[0], bit_strobe[0]}, 8'd3);
        at_cycle(t + 17); check("f34_no_done", {7'b0, done[0]}, 8'd0);
        at_cycle(t + 18); check("f34_k2", {6'b0, seq_out[0], bit_strobe[0]}, 8'd1);
        at_cycle(t + 26); check("f34_done", {7'b0, done[0]}, 8'd1);
        at_cycle(t + 29);

        // DIV=1 with start held: DONE ignores start, re-accept the cycle after.
        pattern = 4'b1001; repeat_cnt = 4'd1; start = 3'b100; t = cyc;
        at_cycle(t + 5); check("b2b_done", {6'b0, done[2], ready[2]}, 8'd2);
        at_cycle(t + 6); check("b2b_ready", {6'b0, ready[2], busy[2]}, 8'd2);
        at_cycle(t + 7); check("b2b_next", {5'b0, busy[2], seq_out[2], bit_strobe[2]}, 8'd7);
        at_cycle(t + 8); start = '0;
        at_cycle(t + 15);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
